// File: rtl/sysbus_fetch_pkg.sv
// Shared types and constants for the Sysbus instruction fetch front end.
package sysbus_fetch_pkg;

  // Sysbus command and target encodings, matching Sysbus.defs.
  localparam logic       SYSBUS_READ   = 1'b1;
  localparam logic [3:0] SYSBUS_MEMORY = 4'b0001;

  // Request tag for a memory read: SYSBUS_READ<<12 | SYSBUS_MEMORY<<8.
  localparam logic [12:0] SYSBUS_READ_MEM_TAG = {SYSBUS_READ, SYSBUS_MEMORY, 8'h00};

  // Fetch sequencer states.
  typedef enum logic [2:0] {
    IDLE,
    REQ,
    RESP,
    DRAIN,
    HALT
  } fetch_state_t;

  // Instruction FIFO entry for the default 32-bit instruction width.
  typedef struct packed {
    logic [31:0] insn;
    logic [63:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_insn_fifo.sv
// Instruction FIFO: up to IPB pushes and one pop per cycle, with flush.
// Pushed lanes are packed in lane order into consecutive slots.
module fetch_insn_fifo
  import sysbus_fetch_pkg::*;
#(
  parameter int  DEPTH   = 32,
  parameter int  IPB     = 2,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [IPB-1:0]           push_mask,
  input  entry_t [IPB-1:0]         push_data,
  input  logic                     pop,
  output logic                     empty,
  output entry_t                   head,
  output logic [$clog2(DEPTH):0]   free
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  entry_t         mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  count;
  logic [PW-1:0]  n_push;
  logic [PW-1:0]  slot [IPB];
  logic           do_pop;

  assign count  = wr_ptr - rd_ptr;
  assign empty  = (count == '0);
  assign free   = PW'(DEPTH) - count;
  assign do_pop = pop && !empty;
  assign head   = mem[rd_ptr[AW-1:0]];

  // Slot for each lane: write pointer plus the number of enabled lanes below it.
  always_comb begin
    n_push = '0;
    for (int k = 0; k < IPB; k++) begin
      slot[k] = wr_ptr + n_push;
      if (push_mask[k]) n_push = n_push + PW'(1);
    end
  end

  // Storage write; a flush discards any same-cycle push.
  always_ff @(posedge clk) begin
    for (int k = 0; k < IPB; k++) begin
      if (push_mask[k] && !flush) mem[slot[k][AW-1:0]] <= push_data[k];
    end
  end

  // Pointer update; pointers carry one extra bit and wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + n_push;
      rd_ptr <= rd_ptr + PW'(do_pop);
    end
  end

endmodule

// File: rtl/sysbus_fetch_unit.sv
// Sysbus instruction fetch front end: fetches whole lines, splits beats into
// PC-tagged instructions, buffers them and hands them to decode.
// Handshakes: a request is held (bus_reqcyc, bus_req stable) until bus_reqack
// and is never retracted; a response beat is consumed on every cycle with
// bus_respcyc=1 while in RESP/DRAIN (bus_respack mirrors it); an instruction is
// popped when insn_valid && insn_ready.
module sysbus_fetch_unit
  import sysbus_fetch_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int LINE_BEATS     = 8,
  parameter int INSN_WIDTH     = 32,
  parameter int FIFO_DEPTH     = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [63:0]               entry,
  output logic                      bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_reqack,
  input  logic                      bus_respcyc,
  output logic                      bus_respack,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  input  logic                      redirect_valid,
  input  logic [63:0]               redirect_pc,
  output logic                      insn_valid,
  input  logic                      insn_ready,
  output logic [INSN_WIDTH-1:0]     insn,
  output logic [63:0]               insn_pc,
  output logic                      halted
);

  localparam int IPB        = BUS_DATA_WIDTH / INSN_WIDTH;
  localparam int BEAT_BYTES = BUS_DATA_WIDTH / 8;
  localparam int INSN_BYTES = INSN_WIDTH / 8;
  localparam int LINE_BYTES = LINE_BEATS * BEAT_BYTES;
  localparam int LINE_INSNS = LINE_BEATS * IPB;
  localparam int CW         = $clog2(LINE_BEATS) + 1;
  localparam int FW         = $clog2(FIFO_DEPTH) + 1;
  localparam logic [63:0] LINE_MASK = ~(64'(LINE_BYTES) - 64'd1);

  typedef struct packed {
    logic [INSN_WIDTH-1:0] insn;
    logic [63:0]           pc;
  } entry_t;

  fetch_state_t    state_q, state_d;
  logic [63:0]     fetch_pc_q, fetch_pc_d;
  logic [63:0]     skip_pc_q, skip_pc_d;
  logic [63:0]     req_addr_q, req_addr_d;
  logic [63:0]     beat_addr_q, beat_addr_d;
  logic [CW-1:0]   beat_cnt_q, beat_cnt_d;
  logic            halt_pending_q, halt_pending_d;
  logic            redir_pending_q, redir_pending_d;

  entry_t [IPB-1:0] push_data;
  logic [IPB-1:0]   push_mask;
  entry_t           head;
  logic [FW-1:0]    fifo_free;
  logic             fifo_empty;
  logic             pop;
  logic             room;
  logic             last_beat;
  logic             halt_seen;
  logic             seen_zero;
  logic             unused_resptag;

  assign unused_resptag = ^bus_resptag;

  assign bus_reqtag = BUS_TAG_WIDTH'(SYSBUS_READ_MEM_TAG);
  assign bus_req    = BUS_DATA_WIDTH'(req_addr_q);
  assign halted     = (state_q == HALT);
  assign insn_valid = !fifo_empty;
  assign insn       = head.insn;
  assign insn_pc    = head.pc;
  assign pop        = insn_valid && insn_ready;
  assign room       = (int'(fifo_free) + int'(pop)) >= LINE_INSNS;
  assign last_beat  = (beat_cnt_q == CW'(LINE_BEATS - 1));

  // Split the current beat into lanes and pick which lanes enter the FIFO:
  // lanes below skip_pc are dropped, and nothing at or after a zero word is kept.
  always_comb begin
    seen_zero = halt_pending_q;
    push_mask = '0;
    for (int k = 0; k < IPB; k++) begin
      push_data[k].insn = bus_resp[k*INSN_WIDTH +: INSN_WIDTH];
      push_data[k].pc   = beat_addr_q + 64'(k * INSN_BYTES);
      if (state_q == RESP && bus_respcyc && push_data[k].pc >= skip_pc_q && !seen_zero) begin
        if (push_data[k].insn == '0) seen_zero = 1'b1;
        else                         push_mask[k] = 1'b1;
      end
    end
    halt_seen = seen_zero;
    if (redirect_valid) push_mask = '0;
  end

  // Next-state and bus handshake outputs; redirect overrides the normal flow.
  always_comb begin
    state_d         = state_q;
    fetch_pc_d      = fetch_pc_q;
    skip_pc_d       = skip_pc_q;
    req_addr_d      = req_addr_q;
    beat_addr_d     = beat_addr_q;
    beat_cnt_d      = beat_cnt_q;
    halt_pending_d  = halt_pending_q;
    redir_pending_d = redir_pending_q;
    bus_reqcyc      = 1'b0;
    bus_respack     = 1'b0;

    case (state_q)
      IDLE: begin
        if (room) begin
          state_d    = REQ;
          req_addr_d = fetch_pc_q & LINE_MASK;
        end
      end
      REQ: begin
        bus_reqcyc = 1'b1;
        if (bus_reqack) begin
          beat_cnt_d      = '0;
          beat_addr_d     = req_addr_q;
          state_d         = redir_pending_q ? DRAIN : RESP;
          redir_pending_d = 1'b0;
        end
      end
      RESP: begin
        bus_respack = bus_respcyc;
        if (bus_respcyc) begin
          beat_addr_d    = beat_addr_q + 64'(BEAT_BYTES);
          beat_cnt_d     = beat_cnt_q + CW'(1);
          halt_pending_d = halt_seen;
          if (last_beat) begin
            fetch_pc_d = req_addr_q + 64'(LINE_BYTES);
            skip_pc_d  = req_addr_q + 64'(LINE_BYTES);
            state_d    = halt_seen ? HALT : IDLE;
          end
        end
      end
      DRAIN: begin
        bus_respack = bus_respcyc;
        if (bus_respcyc) begin
          if (last_beat) state_d = IDLE;
          else           beat_cnt_d = beat_cnt_q + CW'(1);
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: state_d = IDLE;
    endcase

    if (redirect_valid) begin
      fetch_pc_d     = redirect_pc;
      skip_pc_d      = redirect_pc;
      halt_pending_d = 1'b0;
      case (state_q)
        REQ: begin
          if (bus_reqack) begin
            state_d         = DRAIN;
            beat_cnt_d      = '0;
            redir_pending_d = 1'b0;
          end else begin
            state_d         = REQ;
            redir_pending_d = 1'b1;
          end
        end
        RESP: begin
          if (bus_respcyc && last_beat) begin
            state_d = IDLE;
          end else begin
            state_d    = DRAIN;
            beat_cnt_d = beat_cnt_q + CW'(bus_respcyc);
          end
        end
        DRAIN: ;
        default: begin
          state_d    = IDLE;
          req_addr_d = req_addr_q;
        end
      endcase
    end
  end

  // Sequencer registers; entry is loaded while reset is held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      fetch_pc_q      <= entry;
      skip_pc_q       <= entry;
      req_addr_q      <= '0;
      beat_addr_q     <= '0;
      beat_cnt_q      <= '0;
      halt_pending_q  <= 1'b0;
      redir_pending_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      fetch_pc_q      <= fetch_pc_d;
      skip_pc_q       <= skip_pc_d;
      req_addr_q      <= req_addr_d;
      beat_addr_q     <= beat_addr_d;
      beat_cnt_q      <= beat_cnt_d;
      halt_pending_q  <= halt_pending_d;
      redir_pending_q <= redir_pending_d;
    end
  end

  fetch_insn_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .IPB     (IPB),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push_mask (push_mask),
    .push_data (push_data),
    .pop       (pop),
    .empty     (fifo_empty),
    .head      (head),
    .free      (fifo_free)
  );

endmodule

// File: tb/tb_sysbus_fetch_unit.sv
// Directed bench for sysbus_fetch_unit with a line-based memory responder.
module tb_sysbus_fetch_unit;

  localparam int LB = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] entry = 64'h1000;
  logic        bus_reqcyc;
  logic [63:0] bus_req;
  logic [12:0] bus_reqtag;
  logic        bus_reqack = 1'b0;
  logic        bus_respcyc = 1'b0;
  logic        bus_respack;
  logic [63:0] bus_resp = '0;
  logic [12:0] bus_resptag = '0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        insn_valid;
  logic        insn_ready = 1'b0;
  logic [31:0] insn;
  logic [63:0] insn_pc;
  logic        halted;

  int n_checks = 0;
  int n_pass   = 0;

  logic [63:0] req_q[$];
  logic [63:0] got_pc_q[$];
  logic [31:0] got_insn_q[$];
  logic [63:0] zero_addr = '1;
  int          cur_beat = -1;
  int          beats_left = 0;
  int          beats_acked = 0;
  logic [63:0] beat_addr = '0;
  logic [63:0] last_req = '0;

  sysbus_fetch_unit dut (
    .clk            (clk),
    .reset          (rst),
    .entry          (entry),
    .bus_reqcyc     (bus_reqcyc),
    .bus_req        (bus_req),
    .bus_reqtag     (bus_reqtag),
    .bus_reqack     (bus_reqack),
    .bus_respcyc    (bus_respcyc),
    .bus_respack    (bus_respack),
    .bus_resp       (bus_resp),
    .bus_resptag    (bus_resptag),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .insn_valid     (insn_valid),
    .insn_ready     (insn_ready),
    .insn           (insn),
    .insn_pc        (insn_pc),
    .halted         (halted)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Memory image: every word is nonzero except the one at zero_addr.
  function automatic logic [31:0] word_at(input logic [63:0] a);
    if (a == zero_addr) return 32'h0;
    return a[31:0] ^ 32'h5A00_0001;
  endfunction

  // Memory responder: acks a request, idles one cycle, then sends LB beats.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        bus_reqack  = 1'b0;
        bus_respcyc = 1'b0;
        beats_left  = 0;
        cur_beat    = -1;
      end else begin
        if (beats_left > 0) begin
          bus_respcyc = 1'b1;
          bus_resp    = {word_at(beat_addr + 64'd4), word_at(beat_addr)};
          cur_beat    = LB - beats_left;
          beat_addr   = beat_addr + 64'd8;
          beats_left  = beats_left - 1;
        end else begin
          bus_respcyc = 1'b0;
          cur_beat    = -1;
        end
        if (bus_reqack) begin
          bus_reqack = 1'b0;
          beats_left = LB;
          beat_addr  = last_req;
        end else if (bus_reqcyc) begin
          bus_reqack = 1'b1;
          last_req   = bus_req;
          req_q.push_back(bus_req);
        end
        #1;
        if (bus_respcyc) begin
          n_checks++;
          if (bus_respack !== 1'b1) $display("FAIL respack: got %b, need 1 while beat presented", bus_respack);
          else n_pass++;
          beats_acked++;
        end
      end
    end
  end

  // Decode-side monitor: records every accepted instruction.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst && insn_valid && insn_ready) begin
        got_pc_q.push_back(insn_pc);
        got_insn_q.push_back(insn);
      end
    end
  end

  task automatic apply_reset(input logic [63:0] e);
    @(negedge clk);
    rst = 1'b1;
    entry = e;
    redirect_valid = 1'b0;
    repeat (2) @(negedge clk);
    req_q.delete();
    got_pc_q.delete();
    got_insn_q.delete();
    beats_acked = 0;
    rst = 1'b0;
  endtask

  task automatic wait_got(input int n, input int budget, input string what);
    int c = 0;
    while (got_pc_q.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    n_checks++;
    if (got_pc_q.size() < n) $display("FAIL %s: timeout with %0d insns, need %0d", what, got_pc_q.size(), n);
    else n_pass++;
  endtask

  task automatic wait_req(input int n, input int budget, input string what);
    int c = 0;
    while (req_q.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    n_checks++;
    if (req_q.size() < n) $display("FAIL %s: timeout with %0d requests, need %0d", what, req_q.size(), n);
    else n_pass++;
  endtask

  task automatic wait_beat(input int b, input string what);
    int c = 0;
    do begin
      @(negedge clk);
      #3;
      c++;
    end while (!(bus_respcyc && cur_beat == b) && c < 200);
    n_checks++;
    if (!(bus_respcyc && cur_beat == b)) $display("FAIL %s: beat %0d never presented", what, b);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    entry = 64'h1000;
    repeat (2) @(negedge clk);
    n_checks++; if (bus_reqcyc !== 1'b0) $display("FAIL rst_reqcyc: got %b, need 0", bus_reqcyc); else n_pass++;
    n_checks++; if (bus_req !== 64'h0) $display("FAIL rst_req: got %h, need 0", bus_req); else n_pass++;
    n_checks++; if (bus_respack !== 1'b0) $display("FAIL rst_respack: got %b, need 0", bus_respack); else n_pass++;
    n_checks++; if (insn_valid !== 1'b0) $display("FAIL rst_insn_valid: got %b, need 0", insn_valid); else n_pass++;
    n_checks++; if (halted !== 1'b0) $display("FAIL rst_halted: got %b, need 0", halted); else n_pass++;
    n_checks++; if (bus_reqtag !== 13'h1100) $display("FAIL reqtag: got %h, need 1100", bus_reqtag); else n_pass++;
  endtask

  task automatic test_basic_line();
    insn_ready = 1'b1;
    apply_reset(64'h1000);
    wait_got(17, 400, "basic_wait");
    n_checks++; if (req_q[0] !== 64'h1000) $display("FAIL basic_req0: got %h, need 1000", req_q[0]); else n_pass++;
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (got_pc_q[i] !== 64'h1000 + 64'(4*i) || got_insn_q[i] !== word_at(64'h1000 + 64'(4*i)))
        $display("FAIL basic_insn%0d: got pc %h insn %h, need pc %h insn %h", i, got_pc_q[i], got_insn_q[i],
                 64'h1000 + 64'(4*i), word_at(64'h1000 + 64'(4*i)));
      else n_pass++;
    end
    n_checks++; if (got_pc_q[16] !== 64'h1040) $display("FAIL basic_next_pc: got %h, need 1040", got_pc_q[16]); else n_pass++;
    n_checks++; if (req_q[1] !== 64'h1040) $display("FAIL basic_req1: got %h, need 1040", req_q[1]); else n_pass++;
  endtask

  task automatic test_skip();
    insn_ready = 1'b1;
    apply_reset(64'h1008);
    wait_got(15, 400, "skip_wait");
    n_checks++; if (req_q[0] !== 64'h1000) $display("FAIL skip_req0: got %h, need 1000", req_q[0]); else n_pass++;
    for (int i = 0; i < 14; i++) begin
      n_checks++;
      if (got_pc_q[i] !== 64'h1008 + 64'(4*i))
        $display("FAIL skip_pc%0d: got %h, need %h", i, got_pc_q[i], 64'h1008 + 64'(4*i));
      else n_pass++;
    end
    n_checks++; if (got_pc_q[14] !== 64'h1040) $display("FAIL skip_line_end: got %h, need 1040", got_pc_q[14]); else n_pass++;
  endtask

  task automatic test_backpressure();
    insn_ready = 1'b0;
    apply_reset(64'h1000);
    repeat (100) @(negedge clk);
    n_checks++; if (req_q.size() != 2) $display("FAIL bp_two_lines: got %0d requests, need 2", req_q.size()); else n_pass++;
    n_checks++; if (req_q[1] !== 64'h1040) $display("FAIL bp_req1: got %h, need 1040", req_q[1]); else n_pass++;
    n_checks++; if (insn_valid !== 1'b1) $display("FAIL bp_valid: got %b, need 1", insn_valid); else n_pass++;
    insn_ready = 1'b1;
    repeat (15) @(negedge clk);
    insn_ready = 1'b0;
    repeat (20) @(negedge clk);
    n_checks++; if (got_pc_q.size() != 15) $display("FAIL bp_pop15: got %0d pops, need 15", got_pc_q.size()); else n_pass++;
    n_checks++; if (req_q.size() != 2) $display("FAIL bp_hold: got %0d requests, need 2", req_q.size()); else n_pass++;
    insn_ready = 1'b1;
    @(negedge clk);
    insn_ready = 1'b0;
    repeat (20) @(negedge clk);
    n_checks++; if (req_q.size() != 3) $display("FAIL bp_third: got %0d requests, need 3", req_q.size()); else n_pass++;
    n_checks++; if (req_q[2] !== 64'h1080) $display("FAIL bp_req2: got %h, need 1080", req_q[2]); else n_pass++;
  endtask

  task automatic test_redirect();
    int acked_at;
    insn_ready = 1'b1;
    apply_reset(64'h1000);
    wait_beat(3, "redir_beat3");
    redirect_valid = 1'b1;
    redirect_pc = 64'h2004;
    acked_at = beats_acked;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    got_pc_q.delete();
    got_insn_q.delete();
    n_checks++; if (insn_valid !== 1'b0) $display("FAIL redir_flush: got valid %b, need 0", insn_valid); else n_pass++;
    wait_req(2, 200, "redir_req_wait");
    n_checks++; if (req_q[1] !== 64'h2000) $display("FAIL redir_req: got %h, need 2000", req_q[1]); else n_pass++;
    n_checks++; if (beats_acked - acked_at != 4) $display("FAIL redir_drain: got %0d beats, need 4", beats_acked - acked_at); else n_pass++;
    wait_got(15, 300, "redir_got_wait");
    n_checks++;
    if (got_pc_q[0] !== 64'h2004 || got_insn_q[0] !== word_at(64'h2004))
      $display("FAIL redir_first: got pc %h insn %h, need pc 2004 insn %h", got_pc_q[0], got_insn_q[0], word_at(64'h2004));
    else n_pass++;
    n_checks++; if (got_pc_q[14] !== 64'h203C) $display("FAIL redir_last: got %h, need 203c", got_pc_q[14]); else n_pass++;
  endtask

  task automatic test_halt();
    int c = 0;
    logic seen;
    insn_ready = 1'b1;
    zero_addr = 64'h1014;
    apply_reset(64'h1000);
    while (halted !== 1'b1 && c < 300) begin
      @(negedge clk);
      c++;
    end
    n_checks++; if (halted !== 1'b1) $display("FAIL halt_wait: halted %b, need 1", halted); else n_pass++;
    repeat (5) @(negedge clk);
    n_checks++; if (got_pc_q.size() != 5) $display("FAIL halt_count: got %0d insns, need 5", got_pc_q.size()); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (got_pc_q[i] !== 64'h1000 + 64'(4*i)) $display("FAIL halt_pc%0d: got %h, need %h", i, got_pc_q[i], 64'h1000 + 64'(4*i));
      else n_pass++;
    end
    n_checks++; if (beats_acked != 8) $display("FAIL halt_beats: got %0d beats, need 8", beats_acked); else n_pass++;
    seen = 1'b0;
    repeat (100) begin
      @(negedge clk);
      #1;
      if (bus_reqcyc) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0) $display("FAIL halt_no_req: got reqcyc %b during halt, need 0", seen); else n_pass++;
    n_checks++; if (halted !== 1'b1) $display("FAIL halt_hold: got %b, need 1", halted); else n_pass++;
    zero_addr = '1;
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 64'h1040;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    n_checks++; if (halted !== 1'b0) $display("FAIL halt_release: got %b, need 0", halted); else n_pass++;
    wait_req(2, 100, "halt_req_wait");
    n_checks++; if (req_q[1] !== 64'h1040) $display("FAIL halt_resume: got %h, need 1040", req_q[1]); else n_pass++;
  endtask

  task automatic test_async_reset();
    insn_ready = 1'b1;
    apply_reset(64'h1000);
    wait_beat(2, "arst_beat2");
    #1;
    entry = 64'h3000;
    rst = 1'b1;
    #1;
    n_checks++; if (bus_reqcyc !== 1'b0) $display("FAIL arst_reqcyc: got %b, need 0", bus_reqcyc); else n_pass++;
    n_checks++; if (bus_respack !== 1'b0) $display("FAIL arst_respack: got %b, need 0", bus_respack); else n_pass++;
    n_checks++; if (insn_valid !== 1'b0) $display("FAIL arst_valid: got %b, need 0", insn_valid); else n_pass++;
    n_checks++; if (bus_req !== 64'h0) $display("FAIL arst_req: got %h, need 0", bus_req); else n_pass++;
    repeat (2) @(negedge clk);
    req_q.delete();
    got_pc_q.delete();
    got_insn_q.delete();
    rst = 1'b0;
    wait_req(1, 50, "arst_req_wait");
    n_checks++; if (req_q[0] !== 64'h3000) $display("FAIL arst_new_entry: got %h, need 3000", req_q[0]); else n_pass++;
    wait_got(1, 100, "arst_got_wait");
    n_checks++; if (got_pc_q[0] !== 64'h3000) $display("FAIL arst_first_pc: got %h, need 3000", got_pc_q[0]); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic_line();
    test_skip();
    test_backpressure();
    test_redirect();
    test_halt();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sysbus_fetch_unit.md
Name: sysbus_fetch_unit

Overview:
Parametrised instruction fetch front end on the Sysbus.
- Issues line-aligned memory read requests starting at `entry` and counts the response beats of each line.
- Splits each beat into INSN_WIDTH instructions and buffers them, each tagged with its PC, in an instruction FIFO.
- Delivers instructions to decode over a valid/ready interface.
- Supports PC redirect with flush of in-flight beats, plus halt detection on an all-zero instruction.

Parameters:
BUS_DATA_WIDTH, 64, Sysbus data width in bits
BUS_TAG_WIDTH, 13, Sysbus tag width
LINE_BEATS, 8, response beats per fetched line
INSN_WIDTH, 32, instruction width; BUS_DATA_WIDTH must be a multiple of it
FIFO_DEPTH, 32, instruction FIFO entries; power of two, >= LINE_BEATS*IPB
Derived: IPB = BUS_DATA_WIDTH/INSN_WIDTH; LINE_BYTES = LINE_BEATS*BUS_DATA_WIDTH/8

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
entry  in  64  program entry PC, sampled while reset is high
bus_reqcyc  out  1  read request valid
bus_req  out  BUS_DATA_WIDTH  line-aligned request address
bus_reqtag  out  BUS_TAG_WIDTH  constant SYSBUS_READ<<12 | SYSBUS_MEMORY<<8
bus_reqack  in  1  request accepted
bus_respcyc  in  1  response beat valid
bus_respack  out  1  response beat consumed
bus_resp  in  BUS_DATA_WIDTH  response data; instruction k in bits [k*INSN_WIDTH +: INSN_WIDTH]
bus_resptag  in  BUS_TAG_WIDTH  ignored
redirect_valid  in  1  redirect fetch to redirect_pc
redirect_pc  in  64  new PC; INSN_WIDTH/8-aligned
insn_valid  out  1  FIFO head valid
insn_ready  in  1  decode accepts head
insn  out  INSN_WIDTH  head instruction
insn_pc  out  64  PC of head instruction
halted  out  1  all-zero instruction seen; fetching stopped

Behaviour:
- Reset values (asynchronous):
  - bus_reqcyc=0, bus_req=0, bus_respack=0, insn_valid=0, halted=0.
  - FIFO empty; state=IDLE; fetch_pc=entry; skip_pc=entry.
- States: IDLE, REQ, RESP, DRAIN, HALT.
- IDLE:
  - Go to REQ when FIFO free entries >= LINE_BEATS*IPB (free count includes a pop in the same cycle).
  - On entry to REQ, register bus_req = fetch_pc with the low log2(LINE_BYTES) bits cleared.
- REQ:
  - bus_reqcyc=1; bus_req held stable until bus_reqack.
  - Acknowledged cycle: clear bus_reqcyc, beat counter=0, beat_addr=bus_req, go to RESP.
- RESP:
  - bus_respack = bus_respcyc (combinational). A beat is consumed on any cycle with bus_respcyc=1.
  - For each consumed beat, for k=0..IPB-1, with pc_k = beat_addr + k*INSN_WIDTH/8:
    - Push instruction k with pc_k only if pc_k >= skip_pc and no earlier zero instruction has occurred.
    - An all-zero instruction is not pushed; it sets a halt_pending flag.
  - After each consumed beat: beat_addr += BUS_DATA_WIDTH/8, counter++.
  - When the counter reaches LINE_BEATS-1 and that beat is consumed:
    - fetch_pc = line base + LINE_BYTES; skip_pc = that value.
    - Go to HALT if halt_pending, else IDLE.
- DRAIN: consume and discard beats (bus_respack = bus_respcyc) until LINE_BEATS beats in total have been taken, then go to IDLE.
- HALT:
  - halted=1; no further requests.
  - The FIFO keeps draining to decode.
  - Only reset or redirect_valid leaves HALT; redirect clears halted and goes to IDLE.
- Redirect (highest priority, any state):
  - Flush the FIFO, including any same-cycle push.
  - fetch_pc = skip_pc = redirect_pc; clear halt_pending.
  - From RESP, go to DRAIN, counting the current-cycle beat if consumed.
  - From REQ:
    - If bus_reqack is high this cycle, go to DRAIN.
    - Otherwise keep bus_reqcyc high with the old address until acked, then go to DRAIN (requests are never retracted).
- FIFO:
  - Pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally.
  - Push and pop in the same cycle are both allowed.
  - A push of up to IPB entries per cycle cannot overflow, by the IDLE reservation rule.
- insn_valid = FIFO not empty. A pop occurs when insn_valid && insn_ready.
- Output latency: the first instruction appears on insn the cycle after its beat is consumed.
- All address arithmetic is 64-bit, modulo 2^64.

Decomposition:
- sysbus_fetch_pkg holds:
  - fetch state enum;
  - fetch_entry_t struct {insn, pc};
  - SYSBUS_READ_MEM_TAG constant built from the existing Sysbus.defs values.
- One sub-module, fetch_insn_fifo, parametrised by depth, entry type and push width IPB.
- The FSM and beat counter stay in the top level.

Test Plan:
1. Entry=0x1000, memory returns nonzero words, insn_ready=1 -> one request at 0x1000; 16 instructions delivered with PCs 0x1000..0x103C in order; next request at 0x1040.
2. Entry=0x1008 -> request at 0x1000; the first 2 instructions (0x1000, 0x1004) are skipped; the first delivered insn_pc=0x1008; 14 instructions delivered.
3. insn_ready=0 with FIFO_DEPTH=32 -> exactly 2 lines fetched; no third bus_reqcyc until at least 16 entries are popped.
4. Redirect to 0x2004 during beat 3 of a line -> FIFO empties the next cycle; the remaining 4 beats are acked and discarded; next request at 0x2000; first insn_pc=0x2004.
5. Zero word at offset 0x1014 -> instructions 0x1000..0x1010 delivered; the remaining line beats are acked; halted=1; bus_reqcyc stays 0 for 100 cycles.
6. Reset asserted mid-RESP (asynchronously, between clock edges) -> all outputs go to 0 immediately; after release the first request is at the new entry.
